// File: rtl/angle_pair_scheduler.sv
// rtl/angle_pair_scheduler.sv - round-robin sharing of one lag-to-angle engine across N_PAIR mic pairs
module angle_pair_scheduler #(
    parameter int N_PAIR   = 4,
    parameter int LAG_W    = 6,
    parameter int ANG_W    = 16,
    parameter int CALC_LAT = 3
) (
    input  logic                      clk_60MHz,
    input  logic                      rst_n,
    input  logic [N_PAIR-1:0]         lag_valid,
    input  logic [N_PAIR*LAG_W-1:0]   lag_bus,
    input  logic                      clr_ovf,
    output logic                      calc_ena,
    output logic [LAG_W-1:0]          calc_lag,
    input  logic [ANG_W-1:0]          calc_angle,
    output logic [N_PAIR*ANG_W-1:0]   angle_bus,
    output logic [N_PAIR-1:0]         angle_valid,
    output logic                      frame_done,
    output logic                      busy,
    output logic [N_PAIR-1:0]         ovf
);

    localparam int IDX_W = (N_PAIR < 2) ? 1 : $clog2(N_PAIR);
    localparam int CNT_W = (CALC_LAT < 2) ? 1 : $clog2(CALC_LAT + 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_PAIR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PAIR - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALC_LAT);
    localparam logic [N_PAIR-1:0] ONE_HOT0 = N_PAIR'(1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [N_PAIR-1:0]     pend;
    logic [LAG_W-1:0]      pend_lag [N_PAIR];
    logic [IDX_W-1:0]      rr;
    logic [IDX_W-1:0]      gnt;
    logic [IDX_W-1:0]      gnt_next;
    logic [CNT_W-1:0]      cnt;
    logic [N_PAIR-1:0]     serviced;
    logic                  issue;
    logic                  capture;
    logic [N_PAIR-1:0]     issue_mask;
    logic [N_PAIR-1:0]     cap_mask;

    // Round-robin search starting at rr, wrapping modulo N_PAIR.
    always_comb begin
        logic [IDX_W:0] sum;
        logic           found;
        gnt_next = '0;
        found    = 1'b0;
        sum      = '0;
        for (int i = 0; i < N_PAIR; i++) begin
            sum = {1'b0, rr} + (IDX_W + 1)'(i);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            if (!found && pend[sum[IDX_W-1:0]]) begin
                found    = 1'b1;
                gnt_next = sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pend) begin
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_LAST) begin
                    capture    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign issue_mask = issue   ? (ONE_HOT0 << gnt_next) : '0;
    assign cap_mask   = capture ? (ONE_HOT0 << gnt)      : '0;
    assign busy       = (state != S_IDLE);

    // Intake: a strobe on the grant cycle refills the slot after the old lag is issued.
    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= '0;
            for (int k = 0; k < N_PAIR; k++) begin
                pend_lag[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_PAIR; k++) begin
                if (lag_valid[k]) begin
                    pend_lag[k] <= lag_bus[k*LAG_W +: LAG_W];
                end
            end
            pend <= (pend & ~issue_mask) | lag_valid;
            ovf  <= (ovf & ~{N_PAIR{clr_ovf}}) | (lag_valid & pend & ~issue_mask);
        end
    end

    // calc_lag stays put through WAIT: the engine samples live lag_diff for its sign.
    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            gnt         <= '0;
            rr          <= '0;
            cnt         <= '0;
            calc_ena    <= 1'b0;
            calc_lag    <= '0;
            angle_bus   <= '0;
            angle_valid <= '0;
            frame_done  <= 1'b0;
            serviced    <= '0;
        end else begin
            angle_valid <= cap_mask;
            frame_done  <= 1'b0;
            if (issue) begin
                gnt      <= gnt_next;
                calc_lag <= pend_lag[gnt_next];
                calc_ena <= 1'b1;
                cnt      <= '0;
            end else if (state == S_WAIT) begin
                cnt <= capture ? '0 : cnt + 1'b1;
            end
            if (capture) begin
                for (int k = 0; k < N_PAIR; k++) begin
                    if (cap_mask[k]) begin
                        angle_bus[k*ANG_W +: ANG_W] <= calc_angle;
                    end
                end
                rr       <= (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
                calc_ena <= 1'b0;
                if ((serviced | cap_mask) == {N_PAIR{1'b1}}) begin
                    serviced   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    serviced <= serviced | cap_mask;
                end
            end
        end
    end

endmodule
